// File: rtl/mm_pkg.sv
// Shared types and constants for the mem_manager read path.
// Used by mm_read_master, its FIFO and user_logic.
package mm_pkg;

  typedef enum logic {
    RD_IDLE,
    RD_READING
  } rd_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/mm_fifo_fwft.sv
// First-word-fall-through FIFO: circular buffer, occupancy counter and registered head.
// Ports: clk, reset (sync, active-low), push/din, pop/dout, empty, used (word count).
module mm_fifo_fwft #(
  parameter int DATAWIDTH      = 32,
  parameter int FIFODEPTH      = 32,
  parameter int FIFODEPTH_LOG2 = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [DATAWIDTH-1:0]      din,
  input  logic                      pop,
  output logic [DATAWIDTH-1:0]      dout,
  output logic                      empty,
  output logic [FIFODEPTH_LOG2:0]   used
);

  localparam int L = FIFODEPTH_LOG2;

  localparam logic [L:0] FULL_CNT = (L+1)'(FIFODEPTH);
  localparam logic [L:0] ONE_CNT  = (L+1)'(1);

  logic [DATAWIDTH-1:0] mem_q [FIFODEPTH];

  logic [L-1:0]         wr_ptr_q, wr_ptr_d;
  logic [L-1:0]         rd_ptr_q, rd_ptr_d;
  logic [L-1:0]         rd_nxt;
  logic [L:0]           cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d;

  logic is_empty;
  logic is_full;
  logic do_pop;
  logic do_push;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == FULL_CNT);
  assign do_pop   = pop & ~is_empty;
  assign do_push  = push & (~is_full | do_pop);
  assign rd_nxt   = rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_nxt;

    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // The head register always mirrors the oldest stored word,
    // and keeps its last value once the buffer drains.
    if (is_empty) begin
      if (do_push) dout_d = din;
    end else if (do_pop) begin
      if (cnt_q > ONE_CNT) dout_d = mem_q[rd_nxt];
      else if (do_push)    dout_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign empty = is_empty;
  assign used  = cnt_q;

endmodule

// File: rtl/mm_read_master.sv
// Avalon-MM pipelined read master: base/length request in, word reads out, FWFT buffer back.
// Ports: control_* request/done, user_* buffer pop side, master_* Avalon-MM master.
module mm_read_master
  import mm_pkg::*;
#(
  parameter int ADDRESSWIDTH    = 28,
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = BYTES_PER_WORD,
  parameter int FIFODEPTH       = 32,
  parameter int FIFODEPTH_LOG2  = 5
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_read_base,
  input  logic [ADDRESSWIDTH-1:0]    control_read_length,
  input  logic                       control_go,
  output logic                       control_done,

  input  logic                       user_read_buffer,
  output logic [DATAWIDTH-1:0]       user_buffer_output_data,
  output logic                       user_data_available,

  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_read,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  input  logic [DATAWIDTH-1:0]       master_readdata,
  input  logic                       master_readdatavalid,
  input  logic                       master_waitrequest
);

  localparam int AW = ADDRESSWIDTH;
  localparam int L  = FIFODEPTH_LOG2;

  localparam logic [AW-1:0] STEP     = AW'(BYTEENABLEWIDTH);
  localparam logic [AW-1:0] LEN_MASK = ~(AW'(BYTEENABLEWIDTH - 1));
  localparam logic [L+1:0]  DEPTH_W  = (L+2)'(FIFODEPTH);

  rd_state_t     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] remain_q, remain_d;
  logic [L:0]    pend_q, pend_d;
  logic          fixed_q, fixed_d;
  logic          done_q, done_d;

  logic [L:0]    fifo_used;
  logic          fifo_empty;
  logic [AW-1:0] masked_len;
  logic [L+1:0]  occupancy;
  logic          has_room;
  logic          rd_req;
  logic          accept;

  assign masked_len = control_read_length & LEN_MASK;

  // Words buffered plus words still in flight must fit in the FIFO,
  // so a returning word always has a free slot.
  assign occupancy = {1'b0, fifo_used} + {1'b0, pend_q};
  assign has_room  = (occupancy < DEPTH_W);

  assign rd_req = (state_q == RD_READING) & (remain_q != '0) & has_room;
  assign accept = rd_req & ~master_waitrequest;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    fixed_d  = fixed_q;
    done_d   = done_q;
    pend_d   = pend_q;

    case ({accept, master_readdatavalid})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase

    unique case (state_q)
      RD_IDLE: begin
        if (control_go) begin
          addr_d   = control_read_base;
          remain_d = masked_len;
          fixed_d  = control_fixed_location;
          if (masked_len != '0) begin
            state_d = RD_READING;
            done_d  = 1'b0;
          end
        end
      end
      RD_READING: begin
        if (accept) begin
          remain_d = remain_q - STEP;
          if (!fixed_q) addr_d = addr_q + STEP;
        end
        // Finish on the edge that lands the last word.
        if ((remain_d == '0) && (pend_d == '0)) begin
          state_d = RD_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= RD_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      pend_q   <= '0;
      fixed_q  <= 1'b0;
      done_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      pend_q   <= pend_d;
      fixed_q  <= fixed_d;
      done_q   <= done_d;
    end
  end

  mm_fifo_fwft #(
    .DATAWIDTH      (DATAWIDTH),
    .FIFODEPTH      (FIFODEPTH),
    .FIFODEPTH_LOG2 (FIFODEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (master_readdatavalid),
    .din   (master_readdata),
    .pop   (user_read_buffer),
    .dout  (user_buffer_output_data),
    .empty (fifo_empty),
    .used  (fifo_used)
  );

  assign control_done        = done_q;
  assign user_data_available = ~fifo_empty;
  assign master_address      = addr_q;
  assign master_read         = rd_req;
  assign master_byteenable   = '1;

endmodule

// File: tb/tb_mm_read_master.sv
// Self-checking bench for mm_read_master.
// Queue-based transfer model plus an in-order Avalon slave with stall and latency knobs.
module tb_mm_read_master;

  localparam int AW    = 28;
  localparam int DW    = 32;
  localparam int BEW   = 4;
  localparam int DEPTH = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           fixed;
  logic [AW-1:0]  base;
  logic [AW-1:0]  len;
  logic           go;
  logic           done;
  logic           pop;
  logic [DW-1:0]  odata;
  logic           avail;
  logic [AW-1:0]  maddr;
  logic           mread;
  logic [BEW-1:0] mbe;
  logic [DW-1:0]  rdata;
  logic           rdv;
  logic           wr;

  always #5 clk = ~clk;

  mm_read_master dut (
    .clk                     (clk),
    .reset                   (reset),
    .control_fixed_location  (fixed),
    .control_read_base       (base),
    .control_read_length     (len),
    .control_go              (go),
    .control_done            (done),
    .user_read_buffer        (pop),
    .user_buffer_output_data (odata),
    .user_data_available     (avail),
    .master_address          (maddr),
    .master_read             (mread),
    .master_byteenable       (mbe),
    .master_readdata         (rdata),
    .master_readdatavalid    (rdv),
    .master_waitrequest      (wr)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] m_fifo [$];
  logic [AW-1:0] m_addr [$];
  logic [DW-1:0] m_words [$];
  int            m_rem = 0;
  int            m_out = 0;
  bit            m_active = 1'b0;
  logic [DW-1:0] m_last = '0;

  logic [DW-1:0] s_data [$];
  int            s_due [$];
  int            lat_min = 1;
  int            lat_max = 1;
  int            stall_idx = -1;
  int            stall_left = 0;
  int            acc_cnt = 0;
  int            popped = 0;
  bit            chk_en = 1'b0;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {16'hAAAA, a[17:2]};
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit            acc;
    logic [DW-1:0] w;
    logic [AW-1:0] masked;
    logic [AW-1:0] a;
    int            n;

    if (chk_en) begin
      check("done", done, !m_active);
      check("avail", avail, m_fifo.size() > 0);
      check("data", odata,
            (m_fifo.size() > 0) ? m_fifo[0] : m_last);
      check("read", mread,
            (m_rem > 0) && ((m_fifo.size() + m_out) < DEPTH));
      if (mread === 1'b1 && m_addr.size() > 0)
        check("addr", maddr, m_addr[0]);
      check("byteen", mbe, 4'hF);
    end

    wr = 1'b0;
    if (mread === 1'b1 && acc_cnt == stall_idx && stall_left > 0) begin
      wr = 1'b1;
      stall_left--;
    end
    if (reset && s_due.size() > 0 && s_due[0] <= cyc) begin
      rdv   = 1'b1;
      rdata = s_data.pop_front();
      void'(s_due.pop_front());
    end else begin
      rdv   = 1'b0;
      rdata = 32'hDEADBEEF;
    end
    acc = (mread === 1'b1) && !wr;

    if (!reset) begin
      m_fifo.delete();
      m_addr.delete();
      m_words.delete();
      s_data.delete();
      s_due.delete();
      m_rem    = 0;
      m_out    = 0;
      m_active = 1'b0;
      m_last   = '0;
    end else begin
      if (acc) begin
        if (m_addr.size() > 0) begin
          check("acc_addr", maddr, m_addr[0]);
          void'(m_addr.pop_front());
        end else begin
          check("extra_read", acc, 1'b0);
        end
        s_data.push_back(word(maddr));
        s_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        m_rem--;
        m_out++;
        acc_cnt++;
      end
      if (pop && m_fifo.size() > 0) begin
        w = m_fifo.pop_front();
        popped++;
        if (m_words.size() > 0) begin
          check("order", w, m_words[0]);
          void'(m_words.pop_front());
        end else begin
          check("extra_word", w, 64'hx);
        end
      end
      if (rdv) begin
        m_fifo.push_back(rdata);
        m_out--;
      end
      if (m_active) begin
        if (m_rem == 0 && m_out == 0) m_active = 1'b0;
      end else if (go) begin
        masked = len & ~28'h3;
        n = int'(masked >> 2);
        for (int i = 0; i < n; i++) begin
          a = base + (fixed ? 28'd0 : 28'(4 * i));
          m_addr.push_back(a);
          m_words.push_back(word(a));
        end
        m_rem = n;
        if (n > 0) m_active = 1'b1;
      end
      if (m_fifo.size() > 0) m_last = m_fifo[0];
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic start(input logic [AW-1:0] b,
                       input logic [AW-1:0] l,
                       input logic f);
    base    = b;
    len     = l;
    fixed   = f;
    acc_cnt = 0;
    popped  = 0;
    go      = 1'b1;
    cycle();
    go      = 1'b0;
  endtask

  task automatic drain(input int budget, input bit do_pop);
    int n = 0;
    pop = do_pop;
    while ((m_active || (do_pop && m_fifo.size() > 0)) && n < budget) begin
      cycle();
      n++;
    end
    pop = 1'b0;
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles required < %0d",
               n, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    fixed = 1'b0;
    base  = '0;
    len   = '0;
    go    = 1'b0;
    pop   = 1'b0;
    rdata = '0;
    rdv   = 1'b0;
    wr    = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    reset  = 1'b1;
    chk_en = 1'b1;

    check("rst_done", done, 1'b1);
    check("rst_avail", avail, 1'b0);
    check("rst_read", mread, 1'b0);
    check("rst_addr", maddr, 28'h0);
    check("rst_data", odata, 32'h0);
    cycle();

    // single word
    start(28'h8000000, 28'd4, 1'b0);
    check("t1_done_low", done, 1'b0);
    drain(20, 1'b0);
    check("t1_done", done, 1'b1);
    check("t1_avail", avail, 1'b1);
    check("t1_data", odata, 32'hAAAA0000);
    pop = 1'b1;
    cycle();
    pop = 1'b0;
    check("t1_popped", avail, 1'b0);
    check("t1_hold", odata, 32'hAAAA0000);

    // block read
    start(28'h8000004, 28'd96, 1'b0);
    drain(300, 1'b1);
    check("t2_words", popped, 24);
    check("t2_reads", acc_cnt, 24);

    // fixed location
    start(28'h8000068, 28'd16, 1'b1);
    drain(100, 1'b1);
    check("t3_reads", acc_cnt, 4);
    check("t3_words", popped, 4);

    // backpressure, random latency
    lat_min    = 1;
    lat_max    = 8;
    stall_idx  = 1;
    stall_left = 5;
    start(28'h8000100, 28'd40, 1'b0);
    drain(400, 1'b1);
    check("t4_words", popped, 10);
    check("t4_stalled", stall_left, 0);
    stall_idx = -1;
    lat_max   = 1;

    // FIFO full
    start(28'h8000200, 28'd256, 1'b0);
    for (int i = 0; i < 60; i++) cycle();
    check("t5_reads_at_full", acc_cnt, 32);
    check("t5_read_off", mread, 1'b0);
    check("t5_busy", done, 1'b0);
    pop = 1'b1;
    cycle();
    pop = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("t5_one_more", acc_cnt, 33);
    drain(1000, 1'b1);
    check("t5_words", popped, 64);
    check("t5_reads", acc_cnt, 64);

    // zero and sub-word lengths
    start(28'h8000300, 28'd0, 1'b0);
    cycle();
    check("t6_len0_done", done, 1'b1);
    start(28'h8000300, 28'd3, 1'b0);
    cycle();
    cycle();
    check("t6_len3_done", done, 1'b1);
    check("t6_len3_read", mread, 1'b0);
    check("t6_no_reads", acc_cnt, 0);

    // go while reading is ignored
    start(28'h8000400, 28'd32, 1'b0);
    cycle();
    base = 28'h1234560;
    len  = 28'd400;
    go   = 1'b1;
    cycle();
    go   = 1'b0;
    drain(200, 1'b1);
    check("t6_ignore_words", popped, 8);

    // address wrap
    start(28'hFFFFFF8, 28'd16, 1'b0);
    drain(100, 1'b1);
    check("t6_wrap_words", popped, 4);

    // reset mid burst
    lat_min = 3;
    lat_max = 3;
    start(28'h8000500, 28'd64, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("t6_rst_done", done, 1'b1);
    check("t6_rst_avail", avail, 1'b0);
    check("t6_rst_read", mread, 1'b0);
    lat_min = 1;
    lat_max = 1;
    start(28'h8000000, 28'd8, 1'b0);
    drain(100, 1'b1);
    check("t6_after_rst", popped, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
